// File: rtl/registrador_pkg.sv
// Shared mode codes and FSM encoding for the universal shift register.
package registrador_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_SHL  = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_RSVD = 3'b111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic logic is_shift_mode(input logic [2:0] m);
        return (m == MODE_SHR) || (m == MODE_SHL) || (m == MODE_ROR) ||
               (m == MODE_ROL) || (m == MODE_ASR);
    endfunction

endpackage

// File: rtl/registrador_universal_desloca_passo.sv
// Single-bit shift/rotate step: next register value and the bit pushed out.
module desloca_passo
    import registrador_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       mode,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q_next,
    output logic             bit_out
);

    always_comb begin
        q_next  = q;
        bit_out = 1'b0;
        case (mode)
            MODE_SHR: begin
                q_next  = {serial_in, q[WIDTH-1:1]};
                bit_out = q[0];
            end
            MODE_SHL: begin
                q_next  = {q[WIDTH-2:0], serial_in};
                bit_out = q[WIDTH-1];
            end
            MODE_ROR: begin
                q_next  = {q[0], q[WIDTH-1:1]};
                bit_out = q[0];
            end
            MODE_ROL: begin
                q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
                bit_out = q[WIDTH-1];
            end
            MODE_ASR: begin
                q_next  = {q[WIDTH-1], q[WIDTH-1:1]};
                bit_out = q[0];
            end
            default: begin
                q_next  = q;
                bit_out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/registrador_universal.sv
// Universal shift register: load, shifts and rotates by N, one bit per clock.
// First step lands on the start edge, so an N-step operation completes in max(N,1) edges.
module registrador_universal
    import registrador_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amount,
    input  logic [WIDTH-1:0] load_data,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic [AMT_W-1:0] cnt;
    logic [2:0]       mode_r;
    logic [2:0]       step_mode;
    logic [WIDTH-1:0] step_q;
    logic             step_out;

    // The start edge already performs a step, so the live mode drives it in IDLE.
    assign step_mode = (state == ST_IDLE) ? mode : mode_r;

    desloca_passo #(.WIDTH(WIDTH)) u_passo (
        .q         (q),
        .mode      (step_mode),
        .serial_in (serial_in),
        .q_next    (step_q),
        .bit_out   (step_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            q          <= '0;
            serial_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cnt        <= '0;
            mode_r     <= MODE_HOLD;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (mode == MODE_LOAD) begin
                            q    <= load_data;
                            done <= 1'b1;
                        end else if (is_shift_mode(mode) && (amount != '0)) begin
                            q          <= step_q;
                            serial_out <= step_out;
                            if (amount == AMT_W'(1)) begin
                                done <= 1'b1;
                            end else begin
                                state  <= ST_SHIFT;
                                busy   <= 1'b1;
                                cnt    <= amount - AMT_W'(1);
                                mode_r <= mode;
                            end
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    q          <= step_q;
                    serial_out <= step_out;
                    cnt        <= cnt - AMT_W'(1);
                    if (cnt == AMT_W'(1)) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_registrador_universal.sv
// Vector table, hand-written reset corner cases and random ops against a reference model.
module tb_registrador_universal;

    localparam int W  = 16;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    mode;
    logic [AW-1:0] amount;
    logic [W-1:0]  load_data;
    logic          serial_in;
    logic [W-1:0]  q;
    logic          serial_out;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q;
    logic         exp_so;

    always #5 clk = ~clk;

    registrador_universal #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .amount     (amount),
        .load_data  (load_data),
        .serial_in  (serial_in),
        .q          (q),
        .serial_out (serial_out),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        logic [2:0]   m;
        int           n;
        logic [W-1:0] ld;
        logic         si;
        logic [W-1:0] eq;
        logic         eso;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, expv);
        end
    endtask

    // Whole-operation result computed directly from the shift/rotate definitions.
    function automatic void ref_op(input logic [2:0] m, input int n, input logic [W-1:0] ld,
                                   input logic si, inout logic [W-1:0] x, inout logic so);
        logic [W-1:0] ones;
        int r;
        ones = '1;
        r = n % W;
        case (m)
            3'd1: x = ld;
            3'd2: if (n > 0) begin
                so = (n <= W) ? x[n-1] : si;
                x  = (n >= W) ? {W{si}} : ((x >> n) | (si ? ~(ones >> n) : '0));
            end
            3'd3: if (n > 0) begin
                so = (n <= W) ? x[W-n] : si;
                x  = (n >= W) ? {W{si}} : ((x << n) | (si ? ~(ones << n) : '0));
            end
            3'd4: if (n > 0) begin
                so = x[(n-1) % W];
                x  = (x >> r) | (x << (W - r));
            end
            3'd5: if (n > 0) begin
                so = x[W-1-((n-1) % W)];
                x  = (x << r) | (x >> (W - r));
            end
            3'd6: if (n > 0) begin
                so = (n <= W) ? x[n-1] : x[W-1];
                x  = W'($signed(x) >>> n);
            end
            default: ;
        endcase
    endfunction

    // Issue one operation (inputs driven just after an edge), check latency, busy length and results.
    task automatic run_op(input logic [2:0] m, input int n, input logic [W-1:0] ld,
                          input logic si, input string name);
        int cyc;
        int busy_cnt;
        int exp_lat;
        int exp_busy;
        logic shift_op;
        shift_op = (m >= 3'd2) && (m <= 3'd6);
        exp_lat  = (shift_op && n > 0) ? n : 1;
        exp_busy = (shift_op && n >= 2) ? n - 1 : 0;
        ref_op(m, n, ld, si, exp_q, exp_so);
        mode = m; amount = AW'(n); load_data = ld; serial_in = si; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        busy_cnt = 0;
        while (!done && cyc < 100) begin
            if (busy) begin
                busy_cnt++;
                start = 1'($urandom);
                mode = 3'($urandom);
                amount = AW'($urandom);
                load_data = W'($urandom);
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk({name, "_latency"}, cyc, exp_lat);
        chk({name, "_busy_cycles"}, busy_cnt, exp_busy);
        chk({name, "_busy_at_done"}, busy, 0);
        chk({name, "_q"}, q, exp_q);
        chk({name, "_serial_out"}, serial_out, exp_so);
    endtask

    vec_t vt[$];

    initial begin
        logic [W-1:0] xm;
        logic         sm;
        logic         saw_done;

        rst = 1'b1; start = 1'b1; mode = 3'd1; amount = '0;
        load_data = 16'hDEAD; serial_in = 1'b0;
        exp_q = '0; exp_so = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_q", q, 0);
        chk("reset_serial_out", serial_out, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;

        vt.push_back('{3'd1, 0,  16'hA5C3, 1'b0, 16'hA5C3, 1'b0});
        vt.push_back('{3'd1, 0,  16'h8001, 1'b0, 16'h8001, 1'b0});
        vt.push_back('{3'd4, 4,  16'h0000, 1'b0, 16'h1800, 1'b0});
        vt.push_back('{3'd1, 0,  16'h8000, 1'b0, 16'h8000, 1'b0});
        vt.push_back('{3'd6, 20, 16'h0000, 1'b0, 16'hFFFF, 1'b1});
        vt.push_back('{3'd1, 0,  16'h00FF, 1'b0, 16'h00FF, 1'b1});
        vt.push_back('{3'd3, 4,  16'h0000, 1'b1, 16'h0FFF, 1'b0});
        vt.push_back('{3'd2, 0,  16'h5555, 1'b1, 16'h0FFF, 1'b0});
        vt.push_back('{3'd7, 5,  16'h5555, 1'b1, 16'h0FFF, 1'b0});
        vt.push_back('{3'd0, 3,  16'h5555, 1'b1, 16'h0FFF, 1'b0});
        vt.push_back('{3'd2, 2,  16'h0000, 1'b0, 16'h03FF, 1'b1});
        vt.push_back('{3'd1, 7,  16'h1234, 1'b0, 16'h1234, 1'b1});
        vt.push_back('{3'd5, 17, 16'h0000, 1'b0, 16'h2468, 1'b0});
        vt.push_back('{3'd2, 20, 16'h0000, 1'b1, 16'hFFFF, 1'b1});

        // Each op starts in the done cycle of the previous one (back-to-back).
        foreach (vt[i]) begin
            run_op(vt[i].m, vt[i].n, vt[i].ld, vt[i].si, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_table_q", i), q, vt[i].eq);
            chk($sformatf("vec%0d_table_so", i), serial_out, vt[i].eso);
        end
        @(posedge clk); #1;
        chk("done_single_pulse", done, 0);

        // Reset in the third busy cycle of a ROL 8 aborts it without a done.
        run_op(3'd1, 0, 16'h5A5A, 1'b0, "pre_abort_load");
        mode = 3'd5; amount = AW'(8); start = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy1", busy, 1);
        start = 1'b1; mode = 3'd1; load_data = 16'hFFFF; amount = AW'(1);
        @(posedge clk); #1;
        start = 1'b0; mode = 3'd3;
        @(posedge clk); #1;
        xm = 16'h5A5A; sm = 1'b0;
        ref_op(3'd5, 3, '0, 1'b0, xm, sm);
        chk("abort_busy3", busy, 1);
        chk("abort_q_mid", q, xm);
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        chk("abort_q", q, 0);
        chk("abort_busy", busy, 0);
        chk("abort_serial_out", serial_out, 0);
        saw_done = done;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            saw_done = saw_done | done;
        end
        chk("abort_no_done", saw_done, 0);
        exp_q = '0; exp_so = 1'b0;

        for (int k = 0; k < 60; k++) begin
            run_op(3'($urandom), int'($urandom_range(0, 31)), W'($urandom),
                   1'($urandom), $sformatf("rnd%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/registrador_universal.md
# registrador_universal

Parametrised universal shift register, successor of the fixed 16-bit shift/load register in the digital-circuits datapath. Supports parallel load, logical and arithmetic shifts and rotations in both directions by a programmable amount, one bit per clock, under a start/busy/done handshake. Sits between the operand input switches and the display/ALU logic as the general-purpose shifting register.

## Interface
- `WIDTH`, default 16: register width in bits; must be at least 2.
- `AMT_W`, default $clog2(WIDTH)+1: width of the shift-amount input.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request an operation; sampled only while `busy`=0.
- `mode` input 3: operation code, captured with `start`.
- `amount` input AMT_W: number of single-bit steps, captured with `start`. Unsigned.
- `load_data` input WIDTH: parallel load value for LOAD.
- `serial_in` input 1: fill bit for SHR/SHL, sampled live on every shift edge.
- `q` output WIDTH: register contents.
- `serial_out` output 1: registered copy of the last bit shifted or rotated out.
- `busy` output 1: a multi-step operation is in progress.
- `done` output 1: one-cycle pulse when the operation has completed.

## Operation
- Modes:
  - 000 HOLD.
  - 001 LOAD.
  - 010 SHR: logical shift right, `serial_in` enters at the MSB.
  - 011 SHL: `serial_in` enters at the LSB.
  - 100 ROR.
  - 101 ROL.
  - 110 ASR: MSB replicated.
  - 111 reserved, behaves exactly as HOLD.
- FSM states:
  - IDLE: `busy`=0. When `start`=1, captures `mode`/`amount` and begins the operation at the same edge.
  - SHIFT: `busy`=1. Performs one step per edge and decrements the step counter. Returns to IDLE after the final step.
- HOLD/reserved: `q` is unchanged. `done` pulses.
- LOAD: `q`<=`load_data` at the start edge. `done` pulses and the FSM stays in IDLE. `amount` is ignored and `serial_out` is unchanged.
- Shift/rotate, amount N:
  - N=0: no change to `q` or `serial_out`. `done` pulses.
  - N≥1: the first step happens at the start edge and N steps happen in total.
- `serial_out` on each step:
  - Right modes: takes `q[0]` before the step.
  - Left modes: takes `q[WIDTH-1]` before the step.
- N may exceed WIDTH:
  - Rotates wrap.
  - Logical shifts fully flush with `serial_in`.
  - ASR saturates to all-sign.
- While `busy`=1, `start`, `mode`, `amount` and `load_data` are ignored. The captured mode is used for the whole operation.
- `start` in the same cycle that `done` is high (FSM back in IDLE) is accepted normally, giving back-to-back operations.

## Timing
- Reset values: `q`=0, `serial_out`=0, `busy`=0, `done`=0, state IDLE, step counter 0.
- Reset wins over any `start` in the same cycle.
- Reset during SHIFT aborts the operation at that edge. No `done` is generated.
- Start accepted at edge E0:
  - HOLD/LOAD/N=0/N=1: the final `q` is visible after E0. `done`=1 for the cycle after E0. `busy` never rises.
  - N≥2: `busy`=1 after E0 through E(N-2). Steps occur at E0..E(N-1). After E(N-1): `busy`=0, `done`=1 for one cycle, and `q` holds the final value.
- Latency is therefore max(N,1) edges. `done` always coincides with the first cycle the final `q` is visible.
- `serial_out` updates on the same edge as each step.

## Structure
- Package `registrador_pkg`: 3-bit mode constants (MODE_HOLD … MODE_ASR, MODE_RSVD) and the FSM state encoding (ST_IDLE, ST_SHIFT).
- Sub-module `desloca_passo` (combinational): inputs `q`, mode, `serial_in`; outputs next `q` and the bit shifted out. Used for every step, including the first.
- The top level holds the FSM, step counter (AMT_W bits), captured mode and output registers.

## Test plan
All scenarios use WIDTH=16.
- Reset then LOAD 0xA5C3: `q`=0xA5C3 after one edge, `done` pulse, `busy` stays 0, `serial_out`=0.
- From 0x8001, ROR amount=4: `busy` high for 3 cycles, `q`=0x1800 with `done` after the 4th edge, `serial_out`=0.
- From 0x8000, ASR amount=20: `q`=0xFFFF after 20 edges. From 0x00FF, SHL amount=4 with `serial_in`=1: `q`=0x0FFF and `serial_out`=0.
- Shift amount=0 and mode 111 with `start`: `q` unchanged, `done` one cycle after start, `busy` never 1.
- During ROL amount=8, toggle `start`/`mode`/`load_data`: all ignored. Assert `rst` on the 3rd busy cycle: next cycle `q`=0, `busy`=0, and `done` never pulses.
- Back-to-back: a new `start` (LOAD 0x1234) in the `done` cycle of a SHR amount=2 is accepted, giving `q`=0x1234 and a second `done` the next cycle.
